// File: rtl/and_or_pkg.sv
// Shared types and defaults for the AND/OR stage and its run-length monitor.
package and_or_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } run_state_e;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned REC_W     = CNT_W_DEF + 1;

    // Record is {length, saturated}.
    function automatic int unsigned rec_width(input int unsigned cnt_w);
        return cnt_w + 1;
    endfunction

endpackage

// File: rtl/run_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only with a same-cycle pop.
module run_fifo
    import and_or_pkg::*;
#(
    parameter int unsigned W     = REC_W,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, rptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem_q[rptr_q[AW-1:0]];
    end

    // Storage is reset so the head reads 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= wdata;
                wptr_q                <= wptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/n_run_monitor.sv
// Measures runs of consecutive sampled 1s on n_in and queues {length, saturated} records.
// Define N_RUN_MON_GLITCH_FILTER_EN to discard completed runs of length 1.
module n_run_monitor
    import and_or_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             n_in,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_len,
    output logic             out_sat,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned      RecW   = rec_width(CNT_W);
    localparam logic [CNT_W-1:0] CntMax = '1;

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             ovf_q;
    logic             run_end, push_req, pop;
    logic             fifo_full, fifo_empty;
    logic [RecW-1:0]  head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (n_in) begin
                        cnt_d   = CNT_W'(1);
                        sat_d   = 1'b0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!n_in) begin
                        state_d = StIdle;
                    end else if (cnt_q == CntMax) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy    = (state_q == StRun);
        run_end = (state_q == StRun) && en && !n_in;
`ifdef N_RUN_MON_GLITCH_FILTER_EN
        push_req = run_end && (cnt_q != CNT_W'(1));
`else
        push_req = run_end;
`endif
    end

    assign pop = out_valid && out_ready;

    // A same-cycle pop frees a slot, so only a push into a full FIFO without a pop is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            ovf_q <= 1'b1;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end
    end

    run_fifo #(
        .W     (RecW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata ({cnt_q, sat_q}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_len   = head[RecW-1:1];
    assign out_sat   = head[0];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_n_run_monitor.sv
// Randomised and directed bench for n_run_monitor against a queue-based run-length model.
module tb_n_run_monitor;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned LenMax = (1 << CNT_W) - 1;
`ifdef N_RUN_MON_GLITCH_FILTER_EN
    localparam bit Filter = 1'b1;
`else
    localparam bit Filter = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, en, n_in, clr, out_ready;
    logic             out_valid, out_sat, ovf, busy;
    logic [CNT_W-1:0] out_len;

    always #5 clk = ~clk;

    n_run_monitor #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .n_in      (n_in),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_len   (out_len),
        .out_sat   (out_sat),
        .ovf       (ovf),
        .busy      (busy)
    );

    typedef struct {
        int unsigned len;
        bit          sat;
    } rec_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    rec_t        mq[$];
    bit          m_in_run;
    int unsigned m_run;
    bit          m_ovf;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_in_run = 1'b0;
        m_run    = 0;
        m_ovf    = 1'b0;
    endtask

    // One clock edge worth of behaviour, from the inputs presented before the edge.
    task automatic model_edge();
        bit   full, pop, set;
        rec_t r;
        full = (mq.size() == DEPTH);
        pop  = (mq.size() > 0) && out_ready;
        set  = 1'b0;
        if (pop) void'(mq.pop_front());
        if (en && m_in_run && !n_in && !(Filter && m_run == 1)) begin
            if (full && !pop) begin
                set = 1'b1;
            end else begin
                r.len = (m_run > LenMax) ? LenMax : m_run;
                r.sat = (m_run > LenMax);
                mq.push_back(r);
            end
        end
        if (en) begin
            if (n_in) begin
                m_run    = m_in_run ? m_run + 1 : 1;
                m_in_run = 1'b1;
            end else begin
                m_in_run = 1'b0;
            end
        end
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        check("valid", 32'(out_valid), (mq.size() > 0) ? 1 : 0);
        check("busy", 32'(busy), 32'(m_in_run));
        check("ovf", 32'(ovf), 32'(m_ovf));
        if (mq.size() > 0) begin
            check("len", 32'(out_len), mq[0].len);
            check("sat", 32'(out_sat), 32'(mq[0].sat));
        end
    endtask

    task automatic cycle(input bit e, input bit n, input bit r, input bit c);
        en        = e;
        n_in      = n;
        out_ready = r;
        clr       = c;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_len"}, 32'(out_len), 0);
        check({tag, "_sat"}, 32'(out_sat), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic apply_reset();
        en  = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        reset_check("rst_async");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        bit n_cur, long_mode;
        rst = 1'b1; en = 1'b0; n_in = 1'b0; clr = 1'b0; out_ready = 1'b0;
        model_reset();
        #2;
        reset_check("rst_init");
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Basic run of three.
        cycle(1, 0, 1, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 0, 1, 0);
        check("run3_valid", 32'(out_valid), 1);
        check("run3_len", 32'(out_len), 3);
        cycle(1, 0, 1, 0);
        check("run3_once", 32'(out_valid), 0);

        // Saturation.
        for (int i = 0; i < 20; i++) cycle(1, 1, 1, 0);
        cycle(1, 0, 1, 0);
        check("sat_len", 32'(out_len), LenMax);
        check("sat_flag", 32'(out_sat), 1);
        cycle(1, 0, 1, 0);

        // Overflow on the fifth queued run, drain, then clear.
        for (int k = 0; k < 5; k++) begin
            cycle(1, 1, 0, 0);
            cycle(1, 1, 0, 0);
            cycle(1, 0, 0, 0);
        end
        check("ovf_set", 32'(ovf), 1);
        for (int k = 0; k < 4; k++) cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 1);
        check("ovf_clr", 32'(ovf), 0);

        // Push into a full FIFO alongside a pop.
        for (int k = 0; k < 4; k++) begin
            cycle(1, 1, 0, 0);
            cycle(1, 1, 0, 0);
            cycle(1, 0, 0, 0);
        end
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 1, 0);
        check("full_pop_ovf", 32'(ovf), 0);
        for (int k = 0; k < 5; k++) cycle(1, 0, 1, 0);

        // Enable gaps inside a run.
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        check("en_gap_len", 32'(out_len), 4);
        cycle(1, 0, 1, 0);

        // Reset mid-run with two records queued.
        for (int k = 0; k < 2; k++) begin
            cycle(1, 1, 0, 0);
            cycle(1, 1, 0, 0);
            cycle(1, 0, 0, 0);
        end
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        apply_reset();
        cycle(1, 0, 1, 0);
        check("rst_no_rec", 32'(out_valid), 0);

        // Glitch filter behaviour.
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        check("glitch_head", 32'(out_len), Filter ? 2 : 1);
        for (int k = 0; k < 3; k++) cycle(1, 0, 1, 0);

        // Random traffic with occasional long runs.
        n_cur     = 1'b0;
        long_mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) long_mode = ~long_mode;
            if (long_mode ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0))
                n_cur = ~n_cur;
            cycle($urandom_range(0, 3) != 0, n_cur, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 29) == 0);
            if (i == 1500) apply_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
